// File: rtl/lane_serializer_pkg.sv
// Shared types and helpers for the lane serializer.
package lane_serializer_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Number of slices emitted per channel word.
  function automatic int unsigned calc_beats(input int unsigned word_w,
                                             input int unsigned slice_w);
    return word_w / slice_w;
  endfunction

endpackage

// File: rtl/lane_serializer_slice_shifter.sv
// One channel's load/shift register; presents the slice nearest the output end.
module slice_shifter #(
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned SLICE_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_shift,
  input  logic               i_msb_first,
  input  logic [WORD_W-1:0]  i_word,
  output logic [SLICE_W-1:0] o_slice
);

  logic [WORD_W-1:0] r_word;

  // Capture on load, otherwise move the next slice toward the output end and zero-fill.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_word <= '0;
    end else if (i_load) begin
      r_word <= i_word;
    end else if (i_shift) begin
      if (i_msb_first) begin
        r_word <= r_word << SLICE_W;
      end else begin
        r_word <= r_word >> SLICE_W;
      end
    end
  end

  // Output end is the top slice in MSB-first mode, the bottom slice otherwise.
  assign o_slice = i_msb_first ? r_word[WORD_W-1 -: SLICE_W] : r_word[SLICE_W-1:0];

endmodule

// File: rtl/lane_serializer.sv
// Serializes NUM_CH parallel words into SLICE_W-wide beats, all channels in lockstep.
module lane_serializer
  import lane_serializer_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned SLICE_W = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_CH-1:0][WORD_W-1:0]  in_data,
  input  logic                           in_msb_first,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_CH*SLICE_W-1:0]      out_data,
  output logic                           out_last,
  output logic                           busy
);

  localparam int unsigned BEATS = calc_beats(WORD_W, SLICE_W);
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  // Reject parameter sets that cannot be split into at least two whole slices.
  if (((WORD_W % SLICE_W) != 0) || (BEATS < 2) || (NUM_CH < 1)) begin : g_bad_params
    $error("lane_serializer: illegal NUM_CH/WORD_W/SLICE_W combination");
  end

  state_e               r_state;
  state_e               w_state_nxt;
  logic [CNT_W-1:0]     r_count;
  logic                 r_valid;
  logic                 r_msb_first;
  logic                 w_last;
  logic                 w_accept;
  logic                 w_in_ready;
  logic                 w_load;
  logic                 w_shift;
  logic [NUM_CH-1:0][SLICE_W-1:0] w_slice;

  assign w_last     = r_valid && (r_count == LAST_CNT);
  assign w_accept   = r_valid && out_ready;
  assign w_in_ready = (r_state == IDLE) || (w_accept && w_last);
  assign w_load     = in_valid && w_in_ready;
  assign w_shift    = w_accept && !w_load;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: stay in SHIFT across back-to-back loads.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_load) w_state_nxt = SHIFT;
      SHIFT:   if (w_accept && w_last && !w_load) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Beat counter, output-valid flag and the per-word ordering mode.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count     <= '0;
      r_valid     <= 1'b0;
      r_msb_first <= 1'b0;
    end else if (w_load) begin
      r_count     <= '0;
      r_valid     <= 1'b1;
      r_msb_first <= in_msb_first;
    end else if (w_accept) begin
      if (w_last) begin
        r_count <= '0;
        r_valid <= 1'b0;
      end else begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  // One shift register per channel; the final shift of a word leaves it all-zero.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    slice_shifter #(
      .WORD_W  (WORD_W),
      .SLICE_W (SLICE_W)
    ) u_shifter (
      .clk         (clk),
      .reset       (reset),
      .i_load      (w_load),
      .i_shift     (w_shift),
      .i_msb_first (r_msb_first),
      .i_word      (in_data[g]),
      .o_slice     (w_slice[g])
    );
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_valid;
  assign out_data  = w_slice;
  assign out_last  = w_last;
  assign busy      = (r_state == SHIFT);

endmodule
